// File: rtl/payload_storer.sv
// Write-back stage: packs 64 FP16 results into saturated unsigned bytes
// and streams them to payload memory as eight 64-bit words.
module payload_storer #(
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1023:0] vec_flat,
  input  logic          mem_wr_ready,
  output logic [2:0]    mem_addr,
  output logic          mem_wr_en,
  output logic [63:0]   mem_wr_data,
  output logic          busy,
  output logic          done,
  output logic          sat_flag
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [2:0] BASE = 3'(BASE_ADDR);

  // {clip, byte}
  function automatic logic [8:0] conv(input logic [15:0] h);
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    logic       nan, inf, neg, big, mid;
    logic [8:0] r;
    s   = h[15];
    e   = h[14:10];
    m   = h[9:0];
    nan = (e == 5'd31) && (m != 10'd0);
    inf = !s && (e == 5'd31) && (m == 10'd0);
    neg = s && !nan && ((e != 5'd0) || (m != 10'd0));
    big = !s && (e >= 5'd23) && (e <= 5'd30);
    mid = !s && (e >= 5'd15) && (e <= 5'd22);
    r   = 9'd0;
    unique case (1'b1)
      nan:     r = {1'b1, 8'h00};
      inf:     r = {1'b1, 8'hFF};
      neg:     r = {1'b1, 8'h00};
      big:     r = {1'b1, 8'hFF};
      mid:     r = {1'b0, 8'({1'b1, m} >> (5'd25 - e))};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  // {clip_any, packed bytes}
  function automatic logic [64:0] conv_word(input logic [127:0] w);
    logic [64:0] r;
    logic [8:0]  b;
    r = 65'd0;
    for (int j = 0; j < 8; j++) begin
      b            = conv(w[16*j +: 16]);
      r[8*j +: 8]  = b[7:0];
      r[64]        = r[64] | b[8];
    end
    return r;
  endfunction

  state_t          state, state_nxt;
  logic [1023:0]   shadow, shadow_nxt;
  logic [2:0]      ptr, ptr_nxt, ptr_inc;
  logic [2:0]      addr_nxt;
  logic            en_nxt, busy_nxt, done_nxt, sat_nxt;
  logic [63:0]     data_nxt;
  logic            accept;
  logic [64:0]     first_word, next_word;

  assign accept     = mem_wr_en & mem_wr_ready;
  assign ptr_inc    = ptr + 3'd1;
  assign first_word = conv_word(vec_flat[127:0]);
  assign next_word  = conv_word(shadow[{ptr_inc, 7'd0} +: 128]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = WRITE;
      WRITE:   if (accept && ptr == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shadow_nxt = shadow;
    ptr_nxt    = ptr;
    addr_nxt   = mem_addr;
    en_nxt     = mem_wr_en;
    data_nxt   = mem_wr_data;
    busy_nxt   = busy;
    sat_nxt    = sat_flag;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          // word 0 comes straight from the input, shadow feeds the rest
          shadow_nxt = vec_flat;
          ptr_nxt    = 3'd0;
          addr_nxt   = BASE;
          en_nxt     = 1'b1;
          data_nxt   = first_word[63:0];
          busy_nxt   = 1'b1;
          sat_nxt    = first_word[64];
        end
      end
      WRITE: begin
        if (accept) begin
          if (ptr != 3'd7) begin
            ptr_nxt  = ptr_inc;
            addr_nxt = mem_addr + 3'd1;
            data_nxt = next_word[63:0];
            sat_nxt  = sat_flag | next_word[64];
          end else begin
            en_nxt   = 1'b0;
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      ptr         <= 3'd0;
      mem_addr    <= 3'd0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 64'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      shadow      <= shadow_nxt;
      ptr         <= ptr_nxt;
      mem_addr    <= addr_nxt;
      mem_wr_en   <= en_nxt;
      mem_wr_data <= data_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      sat_flag    <= sat_nxt;
    end
  end

endmodule
